// File: rtl/seq_slot_scheduler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seq_slot_scheduler_pkg
//  Description : Shared sequencer definitions: FSM state encoding, one-hot
//                sequencer status codes and slot write-back status codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_slot_scheduler_pkg;

  // Sequencer FSM states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_WB      = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6,
    ST_STOPPED = 3'd7
  } seq_state_e;

  // One-hot sequencer status codes presented on seq_status
  localparam logic [3:0] SEQ_STATUS_IDLE    = 4'b0000;
  localparam logic [3:0] SEQ_STATUS_BUSY    = 4'b0001;
  localparam logic [3:0] SEQ_STATUS_DONE    = 4'b0010;
  localparam logic [3:0] SEQ_STATUS_ERROR   = 4'b0100;
  localparam logic [3:0] SEQ_STATUS_STOPPED = 4'b1000;

  // Status codes written back into the slot table
  localparam logic [1:0] SLOT_STATUS_DONE  = 2'b10;
  localparam logic [1:0] SLOT_STATUS_ERROR = 2'b11;

  // Map an FSM state onto its externally visible status code
  function automatic logic [3:0] seq_status_of(input seq_state_e state);
    logic [3:0] status;
    case (state)
      ST_FETCH, ST_ISSUE, ST_WAIT, ST_WB: status = SEQ_STATUS_BUSY;
      ST_DONE:                            status = SEQ_STATUS_DONE;
      ST_ERROR:                           status = SEQ_STATUS_ERROR;
      ST_STOPPED:                         status = SEQ_STATUS_STOPPED;
      default:                            status = SEQ_STATUS_IDLE;
    endcase
    return status;
  endfunction

endpackage : seq_slot_scheduler_pkg
`default_nettype wire

// File: rtl/seq_slot_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seq_slot_scheduler
//  Description : Walks a slot table from index 0 up to end_cnt. For each slot
//                it fetches the descriptor, issues one read-DMA and one
//                write-DMA command (zero-length sides skipped), waits for
//                both completions or an error, then writes back status and
//                the cycle count spent in ISSUE/WAIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_slot_scheduler
  import seq_slot_scheduler_pkg::*;
#(
  parameter int INDEX_WIDTH       = 2,
  parameter int ADDR_WIDTH        = 32,
  parameter int SIZE_WIDTH        = 26,
  parameter int SLOT_STATUS_WIDTH = 2,
  parameter int PROFILE_WIDTH     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ctrl_start,
  input  logic                         ctrl_stop,
  input  logic [INDEX_WIDTH-1:0]       end_cnt,
  output logic [3:0]                   seq_status,
  output logic [INDEX_WIDTH-1:0]       main_cnt,
  output logic [INDEX_WIDTH-1:0]       slot_rd_index,
  output logic                         slot_rd_req,
  input  logic                         slot_rd_ready,
  input  logic [ADDR_WIDTH-1:0]        slot_src_addr,
  input  logic [ADDR_WIDTH-1:0]        slot_dst_addr,
  input  logic [SIZE_WIDTH-1:0]        slot_src_size,
  input  logic [SIZE_WIDTH-1:0]        slot_dst_size,
  output logic                         slot_wr_en,
  output logic [INDEX_WIDTH-1:0]       slot_wr_index,
  output logic [SLOT_STATUS_WIDTH-1:0] slot_wr_status,
  output logic [PROFILE_WIDTH-1:0]     slot_wr_profile,
  output logic                         mm2s_cmd_valid,
  input  logic                         mm2s_cmd_ready,
  output logic [ADDR_WIDTH-1:0]        mm2s_cmd_addr,
  output logic [SIZE_WIDTH-1:0]        mm2s_cmd_len,
  output logic                         s2mm_cmd_valid,
  input  logic                         s2mm_cmd_ready,
  output logic [ADDR_WIDTH-1:0]        s2mm_cmd_addr,
  output logic [SIZE_WIDTH-1:0]        s2mm_cmd_len,
  input  logic                         mm2s_done,
  input  logic                         s2mm_done,
  input  logic                         dma_err
);

  localparam logic [SLOT_STATUS_WIDTH-1:0] c_wb_done  = SLOT_STATUS_WIDTH'(SLOT_STATUS_DONE);
  localparam logic [SLOT_STATUS_WIDTH-1:0] c_wb_error = SLOT_STATUS_WIDTH'(SLOT_STATUS_ERROR);

  seq_state_e                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]       main_cnt_q, main_cnt_d;
  logic [ADDR_WIDTH-1:0]        src_addr_q, src_addr_d;
  logic [ADDR_WIDTH-1:0]        dst_addr_q, dst_addr_d;
  logic [SIZE_WIDTH-1:0]        src_size_q, src_size_d;
  logic [SIZE_WIDTH-1:0]        dst_size_q, dst_size_d;
  // "accepted" flags are also set up-front for zero-length sides (skipped)
  logic                         mm2s_acc_q, mm2s_acc_d;
  logic                         s2mm_acc_q, s2mm_acc_d;
  // sticky completion flags, pre-set for zero-length sides
  logic                         mm2s_fin_q, mm2s_fin_d;
  logic                         s2mm_fin_q, s2mm_fin_d;
  logic                         stop_q, stop_d;
  logic [PROFILE_WIDTH-1:0]     profile_q, profile_d;
  logic [SLOT_STATUS_WIDTH-1:0] wb_status_q, wb_status_d;

  logic                         w_busy;
  logic                         w_mm2s_fire;
  logic                         w_s2mm_fire;
  logic                         w_mm2s_acc_nxt;
  logic                         w_s2mm_acc_nxt;
  logic                         w_mm2s_fin_nxt;
  logic                         w_s2mm_fin_nxt;
  logic [PROFILE_WIDTH-1:0]     w_profile_inc;

  // Handshake, flag-merge and saturating-increment helpers
  always_comb begin
    w_busy         = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                     (state_q == ST_WAIT)  || (state_q == ST_WB);
    w_mm2s_fire    = (state_q == ST_ISSUE) && !mm2s_acc_q && mm2s_cmd_ready;
    w_s2mm_fire    = (state_q == ST_ISSUE) && !s2mm_acc_q && s2mm_cmd_ready;
    w_mm2s_acc_nxt = mm2s_acc_q | w_mm2s_fire;
    w_s2mm_acc_nxt = s2mm_acc_q | w_s2mm_fire;
    w_mm2s_fin_nxt = mm2s_fin_q | mm2s_done;
    w_s2mm_fin_nxt = s2mm_fin_q | s2mm_done;
    w_profile_inc  = (&profile_q) ? profile_q : profile_q + PROFILE_WIDTH'(1);
  end

  // Next-state and datapath update for the slot sequencer
  always_comb begin
    state_d     = state_q;
    main_cnt_d  = main_cnt_q;
    src_addr_d  = src_addr_q;
    dst_addr_d  = dst_addr_q;
    src_size_d  = src_size_q;
    dst_size_d  = dst_size_q;
    mm2s_acc_d  = mm2s_acc_q;
    s2mm_acc_d  = s2mm_acc_q;
    mm2s_fin_d  = mm2s_fin_q;
    s2mm_fin_d  = s2mm_fin_q;
    stop_d      = stop_q;
    profile_d   = profile_q;
    wb_status_d = wb_status_q;

    // a stop request is only remembered while a sequence is running
    if (w_busy && ctrl_stop) begin
      stop_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR, ST_STOPPED: begin
        if (ctrl_start) begin
          state_d    = ST_FETCH;
          main_cnt_d = '0;
          stop_d     = 1'b0;
        end
      end

      ST_FETCH: begin
        if (slot_rd_ready) begin
          src_addr_d = slot_src_addr;
          dst_addr_d = slot_dst_addr;
          src_size_d = slot_src_size;
          dst_size_d = slot_dst_size;
          mm2s_acc_d = (slot_src_size == '0);
          s2mm_acc_d = (slot_dst_size == '0);
          mm2s_fin_d = (slot_src_size == '0);
          s2mm_fin_d = (slot_dst_size == '0);
          profile_d  = '0;
          state_d    = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        profile_d  = w_profile_inc;
        mm2s_acc_d = w_mm2s_acc_nxt;
        s2mm_acc_d = w_s2mm_acc_nxt;
        mm2s_fin_d = w_mm2s_fin_nxt;
        s2mm_fin_d = w_s2mm_fin_nxt;
        if (dma_err) begin
          wb_status_d = c_wb_error;
          state_d     = ST_WB;
        end else if (w_mm2s_acc_nxt && w_s2mm_acc_nxt) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        profile_d  = w_profile_inc;
        mm2s_fin_d = w_mm2s_fin_nxt;
        s2mm_fin_d = w_s2mm_fin_nxt;
        if (dma_err) begin
          wb_status_d = c_wb_error;
          state_d     = ST_WB;
        end else if (w_mm2s_fin_nxt && w_s2mm_fin_nxt) begin
          wb_status_d = c_wb_done;
          state_d     = ST_WB;
        end
      end

      ST_WB: begin
        // a stop arriving in the write-back cycle itself is honoured too
        if (wb_status_q == c_wb_error) begin
          state_d = ST_ERROR;
        end else if (stop_q || ctrl_stop) begin
          state_d = ST_STOPPED;
        end else if (main_cnt_q == end_cnt) begin
          state_d = ST_DONE;
        end else begin
          main_cnt_d = main_cnt_q + INDEX_WIDTH'(1);
          state_d    = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      main_cnt_q  <= '0;
      src_addr_q  <= '0;
      dst_addr_q  <= '0;
      src_size_q  <= '0;
      dst_size_q  <= '0;
      mm2s_acc_q  <= 1'b0;
      s2mm_acc_q  <= 1'b0;
      mm2s_fin_q  <= 1'b0;
      s2mm_fin_q  <= 1'b0;
      stop_q      <= 1'b0;
      profile_q   <= '0;
      wb_status_q <= '0;
    end else begin
      state_q     <= state_d;
      main_cnt_q  <= main_cnt_d;
      src_addr_q  <= src_addr_d;
      dst_addr_q  <= dst_addr_d;
      src_size_q  <= src_size_d;
      dst_size_q  <= dst_size_d;
      mm2s_acc_q  <= mm2s_acc_d;
      s2mm_acc_q  <= s2mm_acc_d;
      mm2s_fin_q  <= mm2s_fin_d;
      s2mm_fin_q  <= s2mm_fin_d;
      stop_q      <= stop_d;
      profile_q   <= profile_d;
      wb_status_q <= wb_status_d;
    end
  end

  // Outputs are decoded from registered state only
  always_comb begin
    seq_status      = seq_status_of(state_q);
    main_cnt        = main_cnt_q;
    slot_rd_index   = main_cnt_q;
    slot_rd_req     = (state_q == ST_FETCH);
    mm2s_cmd_valid  = (state_q == ST_ISSUE) && !mm2s_acc_q;
    mm2s_cmd_addr   = src_addr_q;
    mm2s_cmd_len    = src_size_q;
    s2mm_cmd_valid  = (state_q == ST_ISSUE) && !s2mm_acc_q;
    s2mm_cmd_addr   = dst_addr_q;
    s2mm_cmd_len    = dst_size_q;
    slot_wr_en      = (state_q == ST_WB);
    slot_wr_index   = main_cnt_q;
    slot_wr_status  = wb_status_q;
    slot_wr_profile = profile_q;
  end

endmodule : seq_slot_scheduler
`default_nettype wire

// File: tb/tb_seq_slot_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_seq_slot_scheduler
//  Description : Self-checking bench for seq_slot_scheduler. A negedge
//                responder plays slot table and DMA engines; a queue-based
//                reference model predicts the write-back sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_slot_scheduler;

  logic        clk;
  logic        reset;
  logic        ctrl_start;
  logic        ctrl_stop;
  logic [1:0]  end_cnt;
  logic [3:0]  seq_status;
  logic [1:0]  main_cnt;
  logic [1:0]  slot_rd_index;
  logic        slot_rd_req;
  logic        slot_rd_ready;
  logic [31:0] slot_src_addr, slot_dst_addr;
  logic [25:0] slot_src_size, slot_dst_size;
  logic        slot_wr_en;
  logic [1:0]  slot_wr_index;
  logic [1:0]  slot_wr_status;
  logic [31:0] slot_wr_profile;
  logic        mm2s_cmd_valid, mm2s_cmd_ready;
  logic [31:0] mm2s_cmd_addr;
  logic [25:0] mm2s_cmd_len;
  logic        s2mm_cmd_valid, s2mm_cmd_ready;
  logic [31:0] s2mm_cmd_addr;
  logic [25:0] s2mm_cmd_len;
  logic        mm2s_done, s2mm_done, dma_err;

  seq_slot_scheduler dut (
    .clk(clk), .reset(reset), .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
    .end_cnt(end_cnt), .seq_status(seq_status), .main_cnt(main_cnt),
    .slot_rd_index(slot_rd_index), .slot_rd_req(slot_rd_req),
    .slot_rd_ready(slot_rd_ready), .slot_src_addr(slot_src_addr),
    .slot_dst_addr(slot_dst_addr), .slot_src_size(slot_src_size),
    .slot_dst_size(slot_dst_size), .slot_wr_en(slot_wr_en),
    .slot_wr_index(slot_wr_index), .slot_wr_status(slot_wr_status),
    .slot_wr_profile(slot_wr_profile), .mm2s_cmd_valid(mm2s_cmd_valid),
    .mm2s_cmd_ready(mm2s_cmd_ready), .mm2s_cmd_addr(mm2s_cmd_addr),
    .mm2s_cmd_len(mm2s_cmd_len), .s2mm_cmd_valid(s2mm_cmd_valid),
    .s2mm_cmd_ready(s2mm_cmd_ready), .s2mm_cmd_addr(s2mm_cmd_addr),
    .s2mm_cmd_len(s2mm_cmd_len), .mm2s_done(mm2s_done),
    .s2mm_done(s2mm_done), .dma_err(dma_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // slot table contents served to the DUT
  logic [31:0] tbl_src_addr[4], tbl_dst_addr[4];
  logic [25:0] tbl_src_size[4], tbl_dst_size[4];

  // responder configuration (written by the sequence between edges)
  bit rand_mode;
  int fixed_lat;
  int err_slot;
  int stop_target;
  int run_cyc;

  // responder observations
  int cyc, rd_wait, cur_slot, fetch_cyc, wb_seen, stop_at_wb;
  bit stop_sent;
  int mm2s_done_at, s2mm_done_at;
  int mm2s_cnt[4], s2mm_cnt[4];
  int wb_idx[$], wb_st[$], fetch_idx[$];

  task automatic bfm_clear();
    wb_idx.delete(); wb_st.delete(); fetch_idx.delete();
    wb_seen = 0; stop_sent = 0; stop_at_wb = 0; cur_slot = -1; rd_wait = 0;
    mm2s_done_at = -1; s2mm_done_at = -1; fetch_cyc = 0;
    for (int s = 0; s < 4; s++) begin
      mm2s_cnt[s] = 0;
      s2mm_cnt[s] = 0;
    end
  endtask

  // Slot-table and DMA responder: observe outputs, then drive next inputs
  initial begin
    slot_rd_ready = 0; mm2s_cmd_ready = 0; s2mm_cmd_ready = 0;
    mm2s_done = 0; s2mm_done = 0; dma_err = 0; ctrl_stop = 0;
    slot_src_addr = 0; slot_dst_addr = 0; slot_src_size = 0; slot_dst_size = 0;
    cyc = 0;
    bfm_clear();
    forever begin
      @(negedge clk);
      cyc++;
      run_cyc++;
      if (slot_wr_en) begin
        wb_idx.push_back(int'(slot_wr_index));
        wb_st.push_back(int'(slot_wr_status));
        chk("wb_profile", 64'(slot_wr_profile), 64'(cyc - fetch_cyc - 1));
        wb_seen++;
      end
      ctrl_stop = 0;
      if (stop_target != 0 && run_cyc == stop_target && !stop_sent && seq_status == 4'b0001) begin
        ctrl_stop  = 1;
        stop_sent  = 1;
        stop_at_wb = slot_wr_en ? wb_seen : wb_seen + 1;
      end
      slot_rd_ready = 0;
      if (slot_rd_req) begin
        if (rd_wait > 0) rd_wait--;
        else begin
          slot_rd_ready = 1;
          fetch_idx.push_back(int'(slot_rd_index));
          fetch_cyc = cyc;
          cur_slot  = int'(slot_rd_index);
          rd_wait   = rand_mode ? int'($urandom_range(0, 2)) : 0;
        end
      end
      slot_src_addr = tbl_src_addr[slot_rd_index];
      slot_dst_addr = tbl_dst_addr[slot_rd_index];
      slot_src_size = tbl_src_size[slot_rd_index];
      slot_dst_size = tbl_dst_size[slot_rd_index];
      mm2s_cmd_ready = 0;
      if (mm2s_cmd_valid) begin
        mm2s_cmd_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (mm2s_cmd_ready && cur_slot >= 0) begin
          mm2s_cnt[cur_slot]++;
          chk("mm2s_addr", 64'(mm2s_cmd_addr), 64'(tbl_src_addr[cur_slot]));
          chk("mm2s_len", 64'(mm2s_cmd_len), 64'(tbl_src_size[cur_slot]));
          mm2s_done_at = cyc + (rand_mode ? int'($urandom_range(1, 6)) : fixed_lat);
        end
      end
      s2mm_cmd_ready = 0;
      if (s2mm_cmd_valid) begin
        s2mm_cmd_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (s2mm_cmd_ready && cur_slot >= 0) begin
          s2mm_cnt[cur_slot]++;
          chk("s2mm_addr", 64'(s2mm_cmd_addr), 64'(tbl_dst_addr[cur_slot]));
          chk("s2mm_len", 64'(s2mm_cmd_len), 64'(tbl_dst_size[cur_slot]));
          s2mm_done_at = cyc + (rand_mode ? int'($urandom_range(1, 6)) : fixed_lat);
        end
      end
      mm2s_done = (mm2s_done_at == cyc);
      s2mm_done = (s2mm_done_at == cyc);
      if (mm2s_done) mm2s_done_at = -1;
      if (s2mm_done) s2mm_done_at = -1;
      dma_err = 0;
      if (cur_slot >= 0 && cur_slot == err_slot)
        dma_err = (tbl_dst_size[cur_slot] != 0) ? s2mm_done : mm2s_done;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step();
    reset = 0;
    repeat (2) step();
    reset = 1;
    bfm_clear();
  endtask

  task automatic fill_directed(input int zsrc);
    for (int s = 0; s < 4; s++) begin
      tbl_src_addr[s] = 32'h1000 + 32'(s) * 32'h100;
      tbl_dst_addr[s] = 32'h2000 + 32'(s) * 32'h100;
      tbl_src_size[s] = (s == zsrc) ? 26'd0 : 26'd64;
      tbl_dst_size[s] = 26'd64;
    end
  endtask

  task automatic fill_random();
    for (int s = 0; s < 4; s++) begin
      tbl_src_addr[s] = $urandom;
      tbl_dst_addr[s] = $urandom;
      tbl_src_size[s] = ($urandom_range(0, 3) == 0) ? 26'd0 : 26'($urandom_range(1, 4096));
      tbl_dst_size[s] = ($urandom_range(0, 3) == 0) ? 26'd0 : 26'($urandom_range(1, 4096));
    end
  endtask

  // One full sequence, checked against a queue-based model of the slot walk
  task automatic run_and_check(input int endc, input int errs, input int stopt,
                               input bit rnd, input bit poke,
                               output int got_wbs, output logic [3:0] got_status,
                               output int got_main);
    int exp_idx[$];
    int exp_st[$];
    int i, budget, n;
    bit e, fetched;
    logic [3:0] fin;
    do_reset();
    end_cnt = 2'(endc); err_slot = errs; stop_target = stopt; rand_mode = rnd;
    ctrl_start = 1;
    run_cyc = 0;
    step();
    ctrl_start = 0;
    budget = 0;
    while (!(seq_status inside {4'b0010, 4'b0100, 4'b1000}) && budget < 3000) begin
      if (poke && budget == 8 && seq_status == 4'b0001) ctrl_start = 1;
      step();
      ctrl_start = 0;
      budget++;
    end
    chk("terminal_reached", 64'(budget < 3000), 64'd1);
    repeat (3) step();

    i = 0; fin = 4'b0000;
    for (int guard = 0; guard < 8; guard++) begin
      e = (i == errs) && (tbl_src_size[i] != 0 || tbl_dst_size[i] != 0);
      exp_idx.push_back(i);
      exp_st.push_back(e ? 3 : 2);
      if (e) begin fin = 4'b0100; break; end
      if (stop_sent && stop_at_wb == exp_idx.size()) begin fin = 4'b1000; break; end
      if (i == endc) begin fin = 4'b0010; break; end
      i = (i + 1) % 4;
    end

    chk("wb_count", 64'(wb_idx.size()), 64'(exp_idx.size()));
    chk("fetch_count", 64'(fetch_idx.size()), 64'(exp_idx.size()));
    n = (wb_idx.size() < exp_idx.size()) ? wb_idx.size() : exp_idx.size();
    for (int k = 0; k < n; k++) begin
      chk("wb_index", 64'(wb_idx[k]), 64'(exp_idx[k]));
      chk("wb_status", 64'(wb_st[k]), 64'(exp_st[k]));
    end
    n = (fetch_idx.size() < exp_idx.size()) ? fetch_idx.size() : exp_idx.size();
    for (int k = 0; k < n; k++) chk("fetch_index", 64'(fetch_idx[k]), 64'(exp_idx[k]));
    chk("final_status", 64'(seq_status), 64'(fin));
    chk("final_main_cnt", 64'(main_cnt), 64'(i));
    for (int s = 0; s < 4; s++) begin
      fetched = 0;
      foreach (exp_idx[k]) if (exp_idx[k] == s) fetched = 1;
      if (fin == 4'b0100 && s == i) begin
        chk("mm2s_cnt_err_slot", 64'(mm2s_cnt[s] <= 1), 64'd1);
        chk("s2mm_cnt_err_slot", 64'(s2mm_cnt[s] <= 1), 64'd1);
      end else begin
        chk("mm2s_cmd_count", 64'(mm2s_cnt[s]), 64'(fetched && tbl_src_size[s] != 0));
        chk("s2mm_cmd_count", 64'(s2mm_cnt[s]), 64'(fetched && tbl_dst_size[s] != 0));
      end
    end
    got_wbs = wb_idx.size(); got_status = seq_status; got_main = int'(main_cnt);
  endtask

  typedef struct {
    int         endc;
    int         errs;
    int         stopt;
    int         zsrc;
    int         exp_wbs;
    logic [3:0] exp_status;
    int         exp_main;
  } vec_t;

  initial begin
    vec_t       vecs[5];
    int         got_wbs, got_main, budget, ec, es, st;
    logic [3:0] got_status;

    reset = 0; ctrl_start = 0; end_cnt = 0;
    rand_mode = 0; fixed_lat = 10; err_slot = -1; stop_target = 0; run_cyc = 0;
    fill_directed(-1);
    repeat (2) step();
    chk("rst_seq_status", 64'(seq_status), 64'h0);
    chk("rst_main_cnt", 64'(main_cnt), 64'h0);
    chk("rst_rd_req", 64'(slot_rd_req), 64'h0);
    chk("rst_wr_en", 64'(slot_wr_en), 64'h0);
    chk("rst_mm2s_valid", 64'(mm2s_cmd_valid), 64'h0);
    chk("rst_s2mm_valid", 64'(s2mm_cmd_valid), 64'h0);
    reset = 1;

    // end, err slot, stop cycle, zero-src slot, wb count, final status, main
    vecs[0] = '{0, -1, 0, -1, 1, 4'b0010, 0};
    vecs[1] = '{3, -1, 0, -1, 4, 4'b0010, 3};
    vecs[2] = '{3,  1, 0, -1, 2, 4'b0100, 1};
    vecs[3] = '{2, -1, 6, -1, 1, 4'b1000, 0};
    vecs[4] = '{1, -1, 0,  0, 2, 4'b0010, 1};
    for (int v = 0; v < 5; v++) begin
      fill_directed(vecs[v].zsrc);
      run_and_check(vecs[v].endc, vecs[v].errs, vecs[v].stopt, 1'b0, 1'b0,
                    got_wbs, got_status, got_main);
      chk("vec_wb_count", 64'(got_wbs), 64'(vecs[v].exp_wbs));
      chk("vec_status", 64'(got_status), 64'(vecs[v].exp_status));
      chk("vec_main_cnt", 64'(got_main), 64'(vecs[v].exp_main));
    end

    // zero-length read side, then reset while waiting on the write DMA
    fill_directed(-1);
    tbl_src_size[0] = 26'd0;
    tbl_dst_size[0] = 26'd32;
    fixed_lat = 40;
    do_reset();
    end_cnt = 0; err_slot = -1; stop_target = 0; rand_mode = 0;
    ctrl_start = 1;
    step();
    ctrl_start = 0;
    budget = 0;
    while (s2mm_cnt[0] == 0 && budget < 50) begin step(); budget++; end
    chk("s2mm_issued", 64'(s2mm_cnt[0]), 64'd1);
    repeat (3) step();
    chk("wait_busy", 64'(seq_status), 64'h1);
    chk("no_mm2s_cmd", 64'(mm2s_cnt[0]), 64'd0);
    chk("s2mm_once", 64'(s2mm_cnt[0]), 64'd1);
    reset = 0;
    #1;
    chk("abort_seq_status", 64'(seq_status), 64'h0);
    chk("abort_main_cnt", 64'(main_cnt), 64'h0);
    chk("abort_rd_req", 64'(slot_rd_req), 64'h0);
    chk("abort_wr_en", 64'(slot_wr_en), 64'h0);
    chk("abort_mm2s_valid", 64'(mm2s_cmd_valid), 64'h0);
    chk("abort_s2mm_valid", 64'(s2mm_cmd_valid), 64'h0);
    chk("abort_s2mm_len", 64'(s2mm_cmd_len), 64'h0);
    chk("abort_profile", 64'(slot_wr_profile), 64'h0);
    repeat (2) step();
    reset = 1;
    repeat (50) step();
    chk("abort_no_writeback", 64'(wb_seen), 64'd0);
    chk("abort_idle", 64'(seq_status), 64'h0);
    fixed_lat = 10;

    // randomized sequences against the reference model
    for (int r = 0; r < 30; r++) begin
      fill_random();
      ec = int'($urandom_range(0, 3));
      es = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 40)) : 0;
      run_and_check(ec, es, st, 1'b1, 1'b1, got_wbs, got_status, got_main);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_seq_slot_scheduler
`default_nettype wire

// File: doc/seq_slot_scheduler.md
SEQ_SLOT_SCHEDULER -- requirements
Module: seq_slot_scheduler

Interface
REQ-001 SHALL have parameters: INDEX_WIDTH, default 2, slot index width (2^INDEX_WIDTH slots); ADDR_WIDTH, default 32, DMA address width; SIZE_WIDTH, default 26, byte-length width; SLOT_STATUS_WIDTH, default 2, slot status width; PROFILE_WIDTH, default 32, cycle-count width.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ctrl_start  in  1  single-cycle start pulse
- ctrl_stop  in  1  single-cycle stop request
- end_cnt  in  INDEX_WIDTH  last slot to execute
- seq_status  out  4  one-hot status: 0001 busy, 0010 done, 0100 error, 1000 stopped, 0000 idle
- main_cnt  out  INDEX_WIDTH  current slot index
- slot_rd_index  out  INDEX_WIDTH  slot table read index
- slot_rd_req  out  1  slot table read request
- slot_rd_ready  in  1  slot table read data valid
- slot_src_addr, slot_dst_addr  in  ADDR_WIDTH  slot addresses
- slot_src_size, slot_dst_size  in  SIZE_WIDTH  slot lengths
- slot_wr_en  out  1  slot write-back strobe
- slot_wr_index  out  INDEX_WIDTH  write-back index
- slot_wr_status  out  SLOT_STATUS_WIDTH  write-back status
- slot_wr_profile  out  PROFILE_WIDTH  write-back cycle count
- mm2s_cmd_valid / mm2s_cmd_ready  out / in  1  read-DMA command handshake
- mm2s_cmd_addr, mm2s_cmd_len  out  ADDR_WIDTH, SIZE_WIDTH  read-DMA command
- s2mm_cmd_valid / s2mm_cmd_ready  out / in  1  write-DMA command handshake
- s2mm_cmd_addr, s2mm_cmd_len  out  ADDR_WIDTH, SIZE_WIDTH  write-DMA command
- mm2s_done, s2mm_done, dma_err  in  1  completion and error pulses

Function
REQ-003 SHALL implement states IDLE, FETCH, ISSUE, WAIT, WB, DONE, ERROR, STOPPED.
REQ-004 In IDLE, DONE, ERROR or STOPPED, ctrl_start SHALL set main_cnt=0 and go to FETCH next cycle; ctrl_start SHALL be ignored in all other states.
REQ-005 In FETCH: slot_rd_req=1 with slot_rd_index=main_cnt until slot_rd_ready; on ready, latch all four slot fields and go to ISSUE.
REQ-006 In ISSUE: mm2s_cmd_valid SHALL be held with latched src addr/len until accepted (valid&&ready), likewise s2mm with dst fields; each command is accepted exactly once; zero-length sides are not issued and count as done; profile counter clears on ISSUE entry.
REQ-007 After both commands are accepted (or skipped): go to WAIT; done pulses arriving during ISSUE SHALL be captured.
REQ-008 In ISSUE and WAIT, profile counter SHALL increment each cycle, saturating at all-ones.
REQ-009 WAIT SHALL set sticky per-side done flags; when both are set, go to WB with status 2'b10.
REQ-010 dma_err in ISSUE or WAIT SHALL go to WB with status 2'b11, with precedence over simultaneous done.
REQ-011 WB SHALL last one cycle: slot_wr_en=1, slot_wr_index=main_cnt, status, profile.
REQ-012 After WB: error -> ERROR; else stop pending -> STOPPED; else main_cnt==end_cnt -> DONE; else main_cnt+1 (wraps modulo 2^INDEX_WIDTH) -> FETCH.
REQ-013 ctrl_stop SHALL be latched while busy and honoured only after WB; it SHALL be ignored in IDLE, DONE, ERROR and STOPPED.
REQ-014 seq_status SHALL be 0001 in FETCH/ISSUE/WAIT/WB, 0010 in DONE, 0100 in ERROR, 1000 in STOPPED, and 0000 in IDLE.

Reset
REQ-015 Reset SHALL force IDLE, main_cnt=0, profile=0, flags cleared, and all valid/req/wr_en outputs 0, mid-transfer included; no write-back of an aborted slot.

Structure
REQ-016 State encodings, seq_status codes and slot status codes (2'b10 done, 2'b11 error) SHALL reside in a shared sequencer package.
REQ-017 Single module; no sub-module required.

Verification
REQ-018 end_cnt=0, slot0 src=0x1000/64, dst=0x2000/64, done pulses after 10 cycles -> both commands once, WB index0 status 2'b10, seq_status=0010.
REQ-019 end_cnt=3, four slots -> WB indices 0,1,2,3 in order, main_cnt=3 at DONE.
REQ-020 dma_err on slot1 simultaneous with s2mm_done -> WB slot1 status 2'b11, seq_status=0100, slot2 never fetched.
REQ-021 ctrl_stop during slot0 WAIT, end_cnt=2 -> slot0 written back 2'b10, then seq_status=1000.
REQ-022 slot src_size=0, dst_size=32 -> no mm2s_cmd_valid, single s2mm command; reset asserted in WAIT -> all outputs 0 next cycle, no slot_wr_en.
